prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 33 +++
 rtl/prog_ram.sv | 45 ++++
 rtl/prog_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader and its program memory:
//   - default program address width (PSIZE_DEF) and instruction width
//     (ISIZE_DEF)
//   - bytes per instruction on the load stream (BYTES_PER_INSTR)
//   - the loader FSM state enumeration (state_e)
//   - unused_mask(): the byte2 bits that lie above the instruction width
// ----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int PSIZE_DEF       = 6;
  localparam int ISIZE_DEF       = 17;
  localparam int BYTES_PER_INSTR = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_B0   = 3'd2,
    ST_B1   = 3'd3,
    ST_B2   = 3'd4,
    ST_CHK  = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  // Byte2 carries instruction bits [isize-1:16]; every bit of byte2 above
  // that slice must be zero. For isize = 24 the mask is empty.
  function automatic logic [7:0] unused_mask(input int isize);
    return 8'(8'hFF << (isize - 16));
  endfunction

endpackage

// File: rtl/prog_ram.sv
// ----------------------------------------------------------------------------
// prog_ram
// 2^Psize x Isize program memory. Synchronous write port driven by the
// loader, combinational read port matching the processor's existing program
// memory (address in, instruction out).
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe, sampled on rising clk
//   wr_addr  in   [Psize-1:0] write address
//   wr_data  in   [Isize-1:0] write data
//   rd_addr  in   [Psize-1:0] read address
//   rd_data  out  [Isize-1:0] read data (combinational)
// ----------------------------------------------------------------------------
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [Psize-1:0] wr_addr,
  input  logic [Isize-1:0] wr_data,
  input  logic [Psize-1:0] rd_addr,
  output logic [Isize-1:0] rd_data
);

  localparam int DEPTH = 1 << Psize;

  logic [Isize-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto plain RAM; the loader
  // rewrites every word it needs, and a reset must leave loaded words intact.
  // NOTE: clocked state is always assigned with <= so every reader of r_mem
  // sees the value from before the edge, regardless of process order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
// Byte-stream program loader. A frame is a LEN byte N (0 means 2^Psize),
// then N instructions of 3 bytes each, least-significant byte first, then
// a CHK byte when LOADER_CHECKSUM_EN is defined. Each assembled instruction
// is written into the local prog_ram, which the processor reads through
// prog_addr / prog_instr. busy holds the processor in reset during a load.
//
// Build option:
//   LOADER_CHECKSUM_EN  adds the CHK state and the XOR accumulator over all
//                       instruction bytes; a CHK mismatch ends in ERR.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   begin a frame (sampled only while idle)
//   in_data     in   [7:0] stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader accepts a byte this cycle
//   wr_en       out  registered program-memory write strobe
//   wr_addr     out  [Psize-1:0] registered write address
//   wr_data     out  [Isize-1:0] registered write instruction
//   busy        out  frame in progress
//   done        out  one-cycle pulse on successful completion
//   err         out  sticky error, cleared by the next accepted start
//   prog_addr   in   [Psize-1:0] processor fetch address
//   prog_instr  out  [Isize-1:0] processor fetch instruction
// ----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int Psize = PSIZE_DEF,
  parameter int Isize = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [Psize-1:0] wr_addr,
  output logic [Isize-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [Psize-1:0] prog_addr,
  output logic [Isize-1:0] prog_instr
);

  localparam int          DEPTH     = 1 << Psize;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  // Remaining-word counter must hold 2^Psize itself (the N=0 case).
  localparam int          CW        = Psize + 1;
  localparam int          HI_BITS   = Isize - 16;
  localparam logic [7:0]  HI_UNUSED = unused_mask(Isize);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_LEN  = ST_LEN;
  localparam logic [2:0] S_B0   = ST_B0;
  localparam logic [2:0] S_B1   = ST_B1;
  localparam logic [2:0] S_B2   = ST_B2;
  localparam logic [2:0] S_DONE = ST_DONE;
  localparam logic [2:0] S_ERR  = ST_ERR;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = ST_CHK;
  localparam logic [2:0] S_LAST = S_CHK;   // state after the final word
`else
  localparam logic [2:0] S_LAST = S_DONE;
`endif

  logic [2:0]       r_state;
  logic [CW-1:0]    r_left;     // instructions still to receive
  logic [7:0]       r_b0;
  logic [7:0]       r_b1;
  logic             r_wr_en;
  logic [Psize-1:0] r_wr_addr;
  logic [Isize-1:0] r_wr_data;
  logic             r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_chk;      // XOR of every instruction byte so far
`endif

  logic             w_active;
  logic             w_xfer;
  logic             w_len_zero;
  logic             w_len_bad;
  logic             w_fmt_bad;
  logic             w_last;
  logic [Isize-1:0] w_word;

`ifdef LOADER_CHECKSUM_EN
  assign w_active = (r_state == S_LEN) || (r_state == S_B0) ||
                    (r_state == S_B1)  || (r_state == S_B2) ||
                    (r_state == S_CHK);
`else
  assign w_active = (r_state == S_LEN) || (r_state == S_B0) ||
                    (r_state == S_B1)  || (r_state == S_B2);
`endif

  assign w_xfer     = in_valid && w_active;
  assign w_len_zero = (in_data == 8'd0);
  // Only reachable when 2^Psize < 255; wider memories accept every N.
  assign w_len_bad  = ({24'd0, in_data} > DEPTH_U);
  assign w_fmt_bad  = |(in_data & HI_UNUSED);
  assign w_last     = (r_left == CW'(1));
  assign w_word     = {in_data[HI_BITS-1:0], r_b1, r_b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chk     <= '0;
`endif
    end else begin
      // Write strobe lasts one cycle; the address advances right after it
      // so it always shows the address of the word being written.
      r_wr_en <= 1'b0;
      if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_LEN;
            r_err     <= 1'b0;
            r_wr_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_chk     <= '0;
`endif
          end
        end

        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_left  <= w_len_zero ? CW'(DEPTH) : CW'(in_data);
              r_state <= S_B0;
            end
          end
        end

        S_B0: begin
          if (w_xfer) begin
            r_b0    <= in_data;
            r_state <= S_B1;
`ifdef LOADER_CHECKSUM_EN
            r_chk   <= r_chk ^ in_data;
`endif
          end
        end

        S_B1: begin
          if (w_xfer) begin
            r_b1    <= in_data;
            r_state <= S_B2;
`ifdef LOADER_CHECKSUM_EN
            r_chk   <= r_chk ^ in_data;
`endif
          end
        end

        S_B2: begin
          if (w_xfer) begin
            // A format error is flagged but the word is still written.
            r_wr_en   <= 1'b1;
            r_wr_data <= w_word;
            r_left    <= r_left - 1'b1;
            if (w_fmt_bad) begin
              r_err <= 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            r_chk   <= r_chk ^ in_data;
`endif
            r_state <= w_last ? S_LAST : S_B0;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            if (in_data == r_chk) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_active;
  assign busy     = w_active;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  prog_ram #(
    .Psize (Psize),
    .Isize (Isize)
  ) u_prog_ram (
    .clk     (clk),
    .wr_en   (r_wr_en),
    .wr_addr (r_wr_addr),
    .wr_data (r_wr_data),
    .rd_addr (prog_addr),
    .rd_data (prog_instr)
  );

endmodule
